// File: rtl/data_route_pkg.sv
// Shared constants for the data_route width converters: default widths, beat count
// and beat-counter sizing.
package data_route_pkg;

    localparam int unsigned IN_W_DEF  = 1536;
    localparam int unsigned OUT_W_DEF = 128;
    localparam int unsigned BEATS_DEF = IN_W_DEF / OUT_W_DEF;

    // Counter width for n beats; never less than one bit so a 1:1 build still elaborates.
    function automatic int unsigned beat_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BEAT_W_DEF = beat_width(BEATS_DEF);

endpackage

// File: rtl/in1536_out128.sv
// Wide-to-narrow AXI-Stream unpacker: one IN_W word out as IN_W/OUT_W beats, slice 0 first.
// Optional macro TLAST_EARLY_TERM_EN ends a word on the first beat whose tlast flag is set.
module in1536_out128
    import data_route_pkg::*;
#(
    parameter  int unsigned IN_W   = IN_W_DEF,
    parameter  int unsigned OUT_W  = OUT_W_DEF,
    localparam int unsigned BEATS  = IN_W / OUT_W,
    localparam int unsigned BEAT_W = beat_width(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [BEATS-1:0]  s_axis_tlast,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [IN_W-1:0]   buf_data;
    logic [BEATS-1:0]  buf_last;
    logic              full;
    logic [BEAT_W-1:0] beat;

    logic final_beat;
    logic out_hs;
    logic final_hs;
    logic capture;

`ifdef TLAST_EARLY_TERM_EN
    assign final_beat = (beat == LAST_BEAT) | buf_last[beat];
`else
    assign final_beat = (beat == LAST_BEAT);
`endif

    assign out_hs        = full & m_axis_tready;
    assign final_hs      = out_hs & final_beat;
    assign s_axis_tready = ~full | final_hs;
    assign capture       = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = buf_data[beat*OUT_W +: OUT_W];
    assign m_axis_tlast  = buf_last[beat];
    assign m_axis_tvalid = full;

    // Capture takes priority over the final-beat clear so a word can follow with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data <= '0;
            buf_last <= '0;
            full     <= 1'b0;
            beat     <= '0;
        end else if (capture) begin
            buf_data <= s_axis_tdata;
            buf_last <= s_axis_tlast;
            full     <= 1'b1;
            beat     <= '0;
        end else if (final_hs) begin
            full     <= 1'b0;
            beat     <= '0;
        end else if (out_hs) begin
            beat     <= beat + 1'b1;
        end
    end

endmodule
